// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared definitions for the iterative multiply/divide unit.
//   op_e     : Op port encodings (bit 1 selects divide, bit 0 selects signed)
//   state_e  : sequencer states
//   cnt_w()  : iteration counter width for a given operand width
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIN  = 2'b10
  } state_e;

  localparam int DEF_WIDTH = 32;

  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core -- one combinational radix-2 step on magnitudes.
//   Multiply: {acc,q} holds partial product / remaining multiplier bits;
//             i_b is the multiplicand. Conditional add, then shift right.
//   Divide  : {acc,q} holds partial remainder / dividend bits shifting into
//             quotient; i_b is the divisor. Shift left, restoring subtract.
// Ports:
//   i_div  in  1        select divide step (only meaningful with MULDIV_DIV_EN)
//   i_acc  in  WIDTH+1  accumulator / partial remainder
//   i_q    in  WIDTH    multiplier / dividend-quotient shift register
//   i_b    in  WIDTH    multiplicand / divisor
//   o_acc  out WIDTH+1  next accumulator
//   o_q    out WIDTH    next shift register
// Config: MULDIV_DIV_EN defined adds the restoring-divide step.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_div,
  input  logic [WIDTH:0]   i_acc,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH:0]   o_acc,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0] w_sum;

  // acc stays below 2^WIDTH after each shift, so WIDTH+1 bits hold the carry
  assign w_sum = i_q[0] ? (i_acc + {1'b0, i_b}) : i_acc;

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   w_sh;
  logic [WIDTH+1:0] w_diff;

  assign w_sh   = {i_acc[WIDTH-1:0], i_q[WIDTH-1]};
  assign w_diff = {1'b0, w_sh} - {2'b00, i_b};
`else
  logic w_unused;
  assign w_unused = i_div;
`endif

  always_comb begin
    o_acc = {1'b0, w_sum[WIDTH:1]};
    o_q   = {w_sum[0], i_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    if (i_div) begin
      if (!w_diff[WIDTH+1]) begin
        o_acc = w_diff[WIDTH:0];
        o_q   = {i_q[WIDTH-2:0], 1'b1};
      end else begin
        o_acc = w_sh;
        o_q   = {i_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative MIPS MULT/MULTU/DIV/DIVU unit with private Hi/Lo.
//   Operands are latched as magnitudes plus sign flags; WIDTH radix-2 steps
//   run in RUN, and the signed fixup is applied on the last step so Hi/Lo
//   already hold the final result while Done is high.
// Ports:
//   Clk, ResetN        clock (rising) / async active-low reset
//   Start, Op          issue request and opcode (00 MULTU,01 MULT,10 DIVU,11 DIV)
//   OperandA/OperandB  multiplicand-dividend / multiplier-divisor
//   HiWrite/LoWrite    MTHI/MTLO strobes, honoured only while idle
//   WriteData          data for MTHI/MTLO
//   Busy               operation in flight (RUN)
//   Done               one-cycle completion pulse (FIN)
//   Hi/Lo              registered result registers
// Config: define MULDIV_DIV_EN to include the divider; without it a divide
//   Start is ignored and the unit stays idle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = cnt_w(WIDTH);

  state_e r_state, w_next;
  logic   w_accept, w_start_ok, w_last;

  logic [CW-1:0]      r_cnt;
  logic               r_div, r_neg_lo, r_neg_hi, r_dz;
  logic [WIDTH:0]     r_acc, w_acc_n;
  logic [WIDTH-1:0]   r_q, r_b, w_q_n;
  logic [WIDTH-1:0]   r_hi, r_lo, w_hi_res, w_lo_res;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [2*WIDTH-1:0] w_prod, w_prod_f;

`ifdef MULDIV_DIV_EN
  assign w_start_ok = Start;
`else
  assign w_start_ok = Start & ~Op[1];
  logic w_unused;
  assign w_unused = ^{r_neg_hi, r_dz};
`endif

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Op[0] marks the signed variants (MULT, DIV)
  assign w_a_neg = Op[0] & OperandA[WIDTH-1];
  assign w_b_neg = Op[0] & OperandB[WIDTH-1];
  assign w_abs_a = w_a_neg ? -OperandA : OperandA;
  assign w_abs_b = w_b_neg ? -OperandB : OperandB;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // FIN behaves like IDLE for acceptance so a Start in the Done cycle chains
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_start_ok) begin
        w_accept = 1'b1;
        w_next   = S_RUN;
      end
      S_RUN:  if (w_last) w_next = S_FIN;
      S_FIN: begin
        w_next = S_IDLE;
        if (w_start_ok) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign Busy = (r_state == S_RUN);
  assign Done = (r_state == S_FIN);

  // ---------------------------------------------------------- datapath
  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .i_div (r_div),
    .i_acc (r_acc),
    .i_q   (r_q),
    .i_b   (r_b),
    .o_acc (w_acc_n),
    .o_q   (w_q_n)
  );

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_cnt    <= '0;
      r_div    <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_dz     <= 1'b0;
      r_acc    <= '0;
      r_q      <= '0;
      r_b      <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_div    <= Op[1];
      r_neg_lo <= w_a_neg ^ w_b_neg;
      r_neg_hi <= w_a_neg;
      r_dz     <= Op[1] & (OperandB == '0);
      r_acc    <= '0;
      // multiply shifts the multiplier through q; divide shifts the dividend
      r_q      <= Op[1] ? w_abs_a : w_abs_b;
      r_b      <= Op[1] ? w_abs_b : w_abs_a;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + CW'(1);
      r_acc <= w_acc_n;
      r_q   <= w_q_n;
    end
  end

  // Final result from the last step's outputs, with sign fixup folded in.
  // Overflow (most-negative / -1) falls out naturally: |q| = 2^(W-1) and its
  // negation wraps back to the dividend.
  assign w_prod = {w_acc_n[WIDTH-1:0], w_q_n};

  always_comb begin
    w_prod_f = r_neg_lo ? -w_prod : w_prod;
    w_hi_res = w_prod_f[2*WIDTH-1:WIDTH];
    w_lo_res = w_prod_f[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    if (r_div) begin
      // divide-by-zero: remainder path reassembles the dividend, quotient forced
      w_hi_res = r_neg_hi ? -w_acc_n[WIDTH-1:0] : w_acc_n[WIDTH-1:0];
      w_lo_res = r_dz ? '1 : (r_neg_lo ? -w_q_n : w_q_n);
    end
`endif
  end

  // Hi/Lo: result lands on the edge entering FIN; MTHI/MTLO only while idle
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == S_RUN && w_last) begin
      r_hi <= w_hi_res;
      r_lo <= w_lo_res;
    end else if (r_state == S_IDLE) begin
      if (HiWrite) r_hi <= WriteData;
      if (LoWrite) r_lo <= WriteData;
    end
  end

  assign Hi = r_hi;
  assign Lo = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
module tb_muldiv_unit;

  localparam int W = 32;

  logic         Clk, ResetN, Start, HiWrite, LoWrite, Busy, Done;
  logic [1:0]   Op;
  logic [W-1:0] OperandA, OperandB, WriteData, Hi, Lo;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .ResetN    (ResetN),
    .Start     (Start),
    .Op        (Op),
    .OperandA  (OperandA),
    .OperandB  (OperandB),
    .HiWrite   (HiWrite),
    .LoWrite   (LoWrite),
    .WriteData (WriteData),
    .Busy      (Busy),
    .Done      (Done),
    .Hi        (Hi),
    .Lo        (Lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Reference: MIPS semantics in plain 64-bit arithmetic. {hi, lo}
  function automatic logic [63:0] ref_result(input logic [1:0] op,
                                             input logic [31:0] a, b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: return {32'b0, a} * {32'b0, b};
      2'b01: return 64'(sa * sb);
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Drive Start for one edge; returns #1 after that edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, b);
    @(negedge Clk);
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  // Count edges until Done (bounded); busy_ok drops if Busy ever low before Done.
  task automatic wait_done(output int n, output bit busy_ok);
    n = 0;
    busy_ok = 1'b1;
    while (Done !== 1'b1 && n < 100) begin
      if (Busy !== 1'b1) busy_ok = 1'b0;
      @(posedge Clk); #1;
      n++;
    end
  endtask

  task automatic go_idle();
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    int cnt;
    #1 ResetN = 1'b0;
    #2;
    total++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl busy=%b done=%b expected 0 0", Busy, Done);
    end
    total++;
    if (Hi !== '0 || Lo !== '0) begin
      bad++; $display("FAIL reset_hilo hi=%h lo=%h expected 0 0", Hi, Lo);
    end
    @(negedge Clk); ResetN = 1'b1;
    // MTHI/MTLO together with Start: write lands, op begins
    @(negedge Clk);
    HiWrite = 1'b1; LoWrite = 1'b1; WriteData = 32'hA5A5_0F0F;
    Start = 1'b1; Op = 2'b00; OperandA = 7; OperandB = 6;
    @(posedge Clk); #1;
    Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
    total++;
    if (Hi !== 32'hA5A5_0F0F || Lo !== 32'hA5A5_0F0F || Busy !== 1'b1) begin
      bad++; $display("FAIL write_with_start hi=%h lo=%h busy=%b expected a5a50f0f a5a50f0f 1", Hi, Lo, Busy);
    end
    repeat (9) @(posedge Clk);
    #3 ResetN = 1'b0;
    #1;
    total++;
    if (Busy !== 1'b0 || Hi !== '0 || Lo !== '0) begin
      bad++; $display("FAIL reset_midrun busy=%b hi=%h lo=%h expected 0 0 0", Busy, Hi, Lo);
    end
    @(negedge Clk); ResetN = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (Done !== 1'b0 || Busy !== 1'b0) cnt++;
    end
    total++;
    if (cnt != 0) begin
      bad++; $display("FAIL reset_no_done active_cycles=%0d expected 0", cnt);
    end
  endtask

  task automatic test_mul_corner();
    int n; bit bok;
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n, bok);
    total++;
    if (n != 32 || !bok) begin
      bad++; $display("FAIL multu_latency edges=%0d busy_ok=%0d expected 32 1", n, bok);
    end
    total++;
    if (Hi !== 32'hFFFF_FFFE || Lo !== 32'h0000_0001 || Busy !== 1'b0) begin
      bad++; $display("FAIL multu_max hi=%h lo=%h busy=%b expected fffffffe 00000001 0", Hi, Lo, Busy);
    end
    go_idle();
    total++;
    if (Done !== 1'b0 || Busy !== 1'b0 || Hi !== 32'hFFFF_FFFE) begin
      bad++; $display("FAIL done_pulse done=%b busy=%b hi=%h expected 0 0 fffffffe", Done, Busy, Hi);
    end
  endtask

  task automatic test_mult_signed();
    int n; bit bok;
    go_idle();
    issue(2'b01, 32'hFFFF_FFFD, 32'd5);
    issue(2'b00, 32'd9, 32'd9);   // arrives while busy: must be dropped
    wait_done(n, bok);
    total++;
    if (n + 1 != 32 || Hi !== 32'hFFFF_FFFF || Lo !== 32'hFFFF_FFF1) begin
      bad++; $display("FAIL mult_neg edges=%0d hi=%h lo=%h expected 32 ffffffff fffffff1", n + 1, Hi, Lo);
    end
    go_idle();
    total++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      bad++; $display("FAIL start_in_busy_queued busy=%b done=%b expected 0 0", Busy, Done);
    end
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div();
    logic [1:0]  t_op [6] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 2'b10};
    logic [31:0] t_a  [6] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd7, 32'hFFFF_FF9C, 32'hFFFF_FFFF};
    logic [31:0] t_b  [6] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 32'd10};
    logic [31:0] t_lo [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h1999_9999};
    logic [31:0] t_hi [6] = '{32'hFFFF_FFFF, 32'd100, 32'd0, 32'd1, 32'hFFFF_FF9C, 32'd5};
    int n; bit bok;
    for (int i = 0; i < 6; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      wait_done(n, bok);
      total++;
      if (n != 32 || !bok || Hi !== t_hi[i] || Lo !== t_lo[i]) begin
        bad++;
        $display("FAIL div_case%0d edges=%0d hi=%h lo=%h expected 32 %h %h",
                 i, n, Hi, Lo, t_hi[i], t_lo[i]);
      end
    end
  endtask
`else
  task automatic test_div_disabled();
    int cnt, n; bit bok;
    go_idle();
    @(negedge Clk);
    HiWrite = 1'b1; LoWrite = 1'b1; WriteData = 32'h0BAD_CAFE;
    @(posedge Clk); #1;
    HiWrite = 1'b0; LoWrite = 1'b0;
    issue(2'b10, 32'd100, 32'd7);
    issue(2'b11, 32'd100, 32'd7);
    cnt = 0;
    repeat (40) begin
      if (Busy !== 1'b0 || Done !== 1'b0) cnt++;
      @(posedge Clk); #1;
    end
    total++;
    if (cnt != 0 || Hi !== 32'h0BAD_CAFE || Lo !== 32'h0BAD_CAFE) begin
      bad++; $display("FAIL div_ignored active=%0d hi=%h lo=%h expected 0 0badcafe 0badcafe", cnt, Hi, Lo);
    end
    issue(2'b00, 32'd3, 32'd4);
    wait_done(n, bok);
    total++;
    if (n != 32 || Lo !== 32'd12 || Hi !== 32'd0) begin
      bad++; $display("FAIL multu_nodiv edges=%0d hi=%h lo=%h expected 32 0 c", n, Hi, Lo);
    end
  endtask
`endif

  task automatic test_hilo_write();
    logic [31:0] lo_save, a, b;
    logic [63:0] exp;
    int n; bit bok;
    go_idle();
    lo_save = Lo;
    @(negedge Clk); HiWrite = 1'b1; WriteData = 32'h0000_1234;
    @(posedge Clk); #1; HiWrite = 1'b0;
    total++;
    if (Hi !== 32'h0000_1234 || Lo !== lo_save) begin
      bad++; $display("FAIL mthi_idle hi=%h lo=%h expected 00001234 %h", Hi, Lo, lo_save);
    end
    @(negedge Clk); LoWrite = 1'b1; WriteData = 32'h0000_9999;
    @(posedge Clk); #1; LoWrite = 1'b0;
    a = $urandom; b = $urandom;
    exp = ref_result(2'b00, a, b);
    issue(2'b00, a, b);
    @(negedge Clk); LoWrite = 1'b1; WriteData = 32'hDEAD_BEEF;
    @(posedge Clk); #1; LoWrite = 1'b0;
    total++;
    if (Lo !== 32'h0000_9999 || Hi !== 32'h0000_1234) begin
      bad++; $display("FAIL mtlo_busy lo=%h hi=%h expected 00009999 00001234", Lo, Hi);
    end
    wait_done(n, bok);
    total++;
    if (Hi !== exp[63:32] || Lo !== exp[31:0]) begin
      bad++; $display("FAIL hilo_overwrite hi=%h lo=%h expected %h %h", Hi, Lo, exp[63:32], exp[31:0]);
    end
    // MTHI during the Done cycle is dropped
    @(negedge Clk); HiWrite = 1'b1; WriteData = 32'hFACE_FACE;
    @(posedge Clk); #1; HiWrite = 1'b0;
    total++;
    if (Hi !== exp[63:32]) begin
      bad++; $display("FAIL mthi_in_done hi=%h expected %h", Hi, exp[63:32]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2;
    logic [63:0] e1, e2;
    int n; bit bok;
    go_idle();
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    e1 = ref_result(2'b01, a1, b1);
    e2 = ref_result(2'b00, a2, b2);
    issue(2'b01, a1, b1);
    wait_done(n, bok);
    total++;
    if (Hi !== e1[63:32] || Lo !== e1[31:0]) begin
      bad++; $display("FAIL b2b_first hi=%h lo=%h expected %h %h", Hi, Lo, e1[63:32], e1[31:0]);
    end
    issue(2'b00, a2, b2);   // Start lands in the Done cycle
    total++;
    if (Busy !== 1'b1 || Done !== 1'b0) begin
      bad++; $display("FAIL b2b_accept busy=%b done=%b expected 1 0", Busy, Done);
    end
    wait_done(n, bok);
    total++;
    if (n != 32 || !bok || Hi !== e2[63:32] || Lo !== e2[31:0]) begin
      bad++; $display("FAIL b2b_second edges=%0d hi=%h lo=%h expected 32 %h %h",
                      n, Hi, Lo, e2[63:32], e2[31:0]);
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [63:0] exp;
    int n; bit bok;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
`ifndef MULDIV_DIV_EN
      op[1] = 1'b0;
`endif
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      exp = ref_result(op, a, b);
      if ($urandom_range(0, 1) == 1) go_idle();
      issue(op, a, b);
      wait_done(n, bok);
      total++;
      if (n != 32 || !bok || Hi !== exp[63:32] || Lo !== exp[31:0]) begin
        bad++;
        $display("FAIL random%0d op=%0d a=%h b=%h edges=%0d hi=%h lo=%h expected 32 %h %h",
                 i, op, a, b, n, Hi, Lo, exp[63:32], exp[31:0]);
      end
    end
  endtask

  initial begin
    ResetN = 1'b1; Start = 1'b0; Op = 2'b00;
    OperandA = '0; OperandB = '0;
    HiWrite = 1'b0; LoWrite = 1'b0; WriteData = '0;
    test_reset();
    test_mul_corner();
    test_mult_signed();
`ifdef MULDIV_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_hilo_write();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
